// File: rtl/vending_machine_param.sv
// rtl/vending_machine_param.sv - parametrised two-coin vending FSM with refund, change train and sales counter
module vending_machine_param #(
    parameter int unsigned PRICE       = 3,
    parameter int unsigned COIN_LO_VAL = 1,
    parameter int unsigned COIN_HI_VAL = 2,
    parameter int unsigned SOLD_W      = 8,
    localparam int unsigned CW         = $clog2(PRICE + COIN_HI_VAL + 1)
) (
    input  logic              sys_clk,
    input  logic              sysRstN,
    input  logic              piHalf,
    input  logic              piOne,
    input  logic              piCancel,
    output logic              OCola,
    output logic              change1,
    output logic              oReject,
    output logic              oBusy,
    output logic [CW-1:0]     oCredit,
    output logic [SOLD_W-1:0] oSoldCnt
);

    localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
    localparam logic [CW-1:0] LO_C     = CW'(COIN_LO_VAL);
    localparam logic [CW-1:0] HI_C     = CW'(COIN_HI_VAL);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    typedef enum logic {
        COLLECT = 1'b0,
        PAYOUT  = 1'b1
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       credit_q;
    logic [CW-1:0]       pay_cnt_q;
    logic                cola_q;
    logic                change_q;
    logic                reject_q;
    logic [SOLD_W-1:0]   sold_q;

    logic                coin_both;
    logic                coin_any;
    logic [CW-1:0]       coin_val;
    logic [CW-1:0]       sum;
    logic [CW-1:0]       chg;

    // Decode the coin inputs into a unit value; both coins at once is illegal and worth nothing.
    always_comb begin
        coin_both = piHalf & piOne;
        coin_any  = piHalf | piOne;
        coin_val  = '0;
        if (piHalf && !piOne) begin
            coin_val = LO_C;
        end else if (piOne && !piHalf) begin
            coin_val = HI_C;
        end
        sum = credit_q + coin_val;
        chg = sum - PRICE_C;
    end

    // Collect/payout FSM; every output is a register so responses land one cycle after sampling.
    always_ff @(posedge sys_clk or negedge sysRstN) begin
        if (!sysRstN) begin
            state_q   <= COLLECT;
            credit_q  <= '0;
            pay_cnt_q <= '0;
            cola_q    <= 1'b0;
            change_q  <= 1'b0;
            reject_q  <= 1'b0;
            sold_q    <= '0;
        end else begin
            cola_q   <= 1'b0;
            change_q <= 1'b0;
            reject_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    reject_q <= coin_both;
                    if (piCancel) begin
                        // Refund wins over vending: a coin arriving with cancel is paid back too.
                        if (sum != '0) begin
                            credit_q  <= '0;
                            change_q  <= 1'b1;
                            pay_cnt_q <= sum - ONE_C;
                            if (sum > ONE_C) begin
                                state_q <= PAYOUT;
                            end
                        end
                    end else if (sum >= PRICE_C) begin
                        cola_q   <= 1'b1;
                        credit_q <= '0;
                        if (sold_q != {SOLD_W{1'b1}}) begin
                            sold_q <= sold_q + 1'b1;
                        end
                        // First change unit goes out alongside the vend pulse.
                        if (chg != '0) begin
                            change_q  <= 1'b1;
                            pay_cnt_q <= chg - ONE_C;
                            if (chg > ONE_C) begin
                                state_q <= PAYOUT;
                            end
                        end
                    end else begin
                        credit_q <= sum;
                    end
                end
                PAYOUT: begin
                    // Busy paying out: coins are bounced, cancel has nothing left to refund.
                    reject_q  <= coin_any;
                    change_q  <= 1'b1;
                    pay_cnt_q <= pay_cnt_q - ONE_C;
                    if (pay_cnt_q == ONE_C) begin
                        state_q <= COLLECT;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign OCola    = cola_q;
    assign change1  = change_q;
    assign oReject  = reject_q;
    assign oBusy    = (state_q == PAYOUT);
    assign oCredit  = credit_q;
    assign oSoldCnt = sold_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// tb/tb_vending_machine_param.sv - directed self-checking bench for vending_machine_param
module tb_vending_machine_param;

    logic clk;
    logic rst_n;
    logic half;
    logic one;
    logic cancel;

    // Instance A: default parameters
    logic       a_cola, a_chg, a_rej, a_busy;
    logic [2:0] a_credit;
    logic [7:0] a_sold;
    // Instance B: PRICE=5, COIN_HI_VAL=4
    logic       b_cola, b_chg, b_rej, b_busy;
    logic [3:0] b_credit;
    logic [7:0] b_sold;
    // Instance C: SOLD_W=2
    logic       c_cola, c_chg, c_rej, c_busy;
    logic [2:0] c_credit;
    logic [1:0] c_sold;

    int n_tests = 0;
    int n_fail  = 0;

    vending_machine_param u_a (
        .sys_clk(clk), .sysRstN(rst_n), .piHalf(half), .piOne(one), .piCancel(cancel),
        .OCola(a_cola), .change1(a_chg), .oReject(a_rej), .oBusy(a_busy),
        .oCredit(a_credit), .oSoldCnt(a_sold)
    );

    vending_machine_param #(.PRICE(5), .COIN_HI_VAL(4)) u_b (
        .sys_clk(clk), .sysRstN(rst_n), .piHalf(half), .piOne(one), .piCancel(cancel),
        .OCola(b_cola), .change1(b_chg), .oReject(b_rej), .oBusy(b_busy),
        .oCredit(b_credit), .oSoldCnt(b_sold)
    );

    vending_machine_param #(.SOLD_W(2)) u_c (
        .sys_clk(clk), .sysRstN(rst_n), .piHalf(half), .piOne(one), .piCancel(cancel),
        .OCola(c_cola), .change1(c_chg), .oReject(c_rej), .oBusy(c_busy),
        .oCredit(c_credit), .oSoldCnt(c_sold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic o, input logic c);
        half   = h;
        one    = o;
        cancel = c;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state
        check("rst_cola",   int'(a_cola),   0);
        check("rst_chg",    int'(a_chg),    0);
        check("rst_rej",    int'(a_rej),    0);
        check("rst_busy",   int'(a_busy),   0);
        check("rst_credit", int'(a_credit), 0);
        check("rst_sold",   int'(a_sold),   0);
        rst_n = 1'b1;
        tick();

        // T1: one, one -> vend with single change pulse
        drive(1'b0, 1'b1, 1'b0); tick();
        check("t1_credit2", int'(a_credit), 2);
        check("t1_nocola",  int'(a_cola),   0);
        drive(1'b0, 1'b1, 1'b0); tick();
        check("t1_cola",    int'(a_cola),   1);
        check("t1_chg",     int'(a_chg),    1);
        check("t1_credit0", int'(a_credit), 0);
        check("t1_sold",    int'(a_sold),   1);
        check("t1_busy",    int'(a_busy),   0);
        drive(1'b0, 1'b0, 1'b0); tick();
        check("t1_chg_end", int'(a_chg),    0);
        check("t1_cola_end",int'(a_cola),   0);

        // T2: half x3 -> vend, no change
        do_reset();
        drive(1'b1, 1'b0, 1'b0); tick();
        check("t2_credit1", int'(a_credit), 1);
        tick();
        check("t2_credit2", int'(a_credit), 2);
        check("t2_nocola",  int'(a_cola),   0);
        tick();
        check("t2_cola",    int'(a_cola),   1);
        check("t2_nochg",   int'(a_chg),    0);
        check("t2_credit0", int'(a_credit), 0);
        drive(1'b0, 1'b0, 1'b0); tick();

        // T3: one, then cancel+one -> 4 refund pulses, busy 3 cycles
        do_reset();
        drive(1'b0, 1'b1, 1'b0); tick();
        check("t3_credit2", int'(a_credit), 2);
        drive(1'b0, 1'b1, 1'b1); tick();
        check("t3_p1_chg",  int'(a_chg),    1);
        check("t3_p1_busy", int'(a_busy),   1);
        check("t3_nocola",  int'(a_cola),   0);
        check("t3_credit0", int'(a_credit), 0);
        drive(1'b0, 1'b0, 1'b0); tick();
        check("t3_p2_chg",  int'(a_chg),    1);
        check("t3_p2_busy", int'(a_busy),   1);
        tick();
        check("t3_p3_chg",  int'(a_chg),    1);
        check("t3_p3_busy", int'(a_busy),   1);
        tick();
        check("t3_p4_chg",  int'(a_chg),    1);
        check("t3_p4_busy", int'(a_busy),   0);
        tick();
        check("t3_end_chg", int'(a_chg),    0);
        check("t3_sold",    int'(a_sold),   0);

        // T4 (instance B): one, one -> vend + 3 change pulses, coin during payout bounced
        do_reset();
        drive(1'b0, 1'b1, 1'b0); tick();
        check("t4_credit4", int'(b_credit), 4);
        drive(1'b0, 1'b1, 1'b0); tick();
        check("t4_cola",    int'(b_cola),   1);
        check("t4_chg1",    int'(b_chg),    1);
        check("t4_busy1",   int'(b_busy),   1);
        drive(1'b0, 1'b0, 1'b0); tick();
        check("t4_chg2",    int'(b_chg),    1);
        check("t4_cola2",   int'(b_cola),   0);
        check("t4_norej",   int'(b_rej),    0);
        drive(1'b1, 1'b0, 1'b0); tick();
        check("t4_chg3",    int'(b_chg),    1);
        check("t4_rej",     int'(b_rej),    1);
        check("t4_credit0", int'(b_credit), 0);
        drive(1'b0, 1'b0, 1'b0); tick();
        check("t4_chg_end", int'(b_chg),    0);
        check("t4_rej_end", int'(b_rej),    0);
        check("t4_credit_e",int'(b_credit), 0);

        // T5: illegal double coin, then reset in the middle of a refund
        do_reset();
        drive(1'b1, 1'b0, 1'b0); tick();
        check("t5_credit1", int'(a_credit), 1);
        drive(1'b1, 1'b1, 1'b0); tick();
        check("t5_rej",     int'(a_rej),    1);
        check("t5_credit_k",int'(a_credit), 1);
        check("t5_nocola",  int'(a_cola),   0);
        drive(1'b0, 1'b1, 1'b1); tick();
        check("t5_ref_chg", int'(a_chg),    1);
        check("t5_ref_busy",int'(a_busy),   1);
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_chg", int'(a_chg),    0);
        check("t5_rst_busy",int'(a_busy),   0);
        check("t5_rst_rej", int'(a_rej),   0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_post_chg",int'(a_chg),    0);
        tick();
        check("t5_post_chg2",int'(a_chg),   0);
        check("t5_post_cr", int'(a_credit), 0);

        // T6 (instance C): saturating 2-bit sales counter over 5 vends
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 1'b0); tick();
            drive(1'b0, 1'b1, 1'b0); tick();
            check($sformatf("t6_cola%0d", i), int'(c_cola), 1);
            check($sformatf("t6_sold%0d", i), int'(c_sold), (i > 3) ? 3 : i);
        end
        drive(1'b0, 1'b0, 1'b0); tick();
        check("t6_a_sold",  int'(a_sold),   5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
